mrr_pathway_output_arbiter: RTL and testbench

//  Packet-level round-robin merge of the NUM_PATHWAYS per-pathway AXI-stream outputs (loopback o_tdata streams)

---
 rtl/mrr_pathway_output_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mrr_pathway_output_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_pathway_output_arbiter.sv
// Packet-level round-robin merge of per-pathway AXI-stream outputs into one host stream,
// with optional header beat, max-length truncation/flush, and masked tx_en OR.

module mrr_poa_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] grant,
  input  logic             data_act,
  input  logic             flush_act,
  input  logic             o_tready,
  output logic             tready
);
  assign tready = (grant == IDX_W'(LANE)) & ((data_act & o_tready) | flush_act);
endmodule

module mrr_pathway_output_arbiter #(
  parameter int NUM_PATHWAYS      = 4,
  parameter int NUM_PATHWAYS_LOG2 = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int PKT_LEN_WIDTH     = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0]   i_tdata,
  input  logic [NUM_PATHWAYS-1:0]              i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]              i_tlast,
  output logic [NUM_PATHWAYS-1:0]              i_tready,
  output logic [DATA_WIDTH-1:0]                o_tdata,
  output logic                                 o_tvalid,
  output logic                                 o_tlast,
  input  logic                                 o_tready,
  input  logic [NUM_PATHWAYS-1:0]              pathway_enable,
  input  logic                                 header_en,
  input  logic [PKT_LEN_WIDTH-1:0]             max_pkt_len,
  input  logic [63:0]                          cur_time,
  input  logic [NUM_PATHWAYS-1:0]              tx_en,
  output logic                                 tx_en_out,
  output logic [NUM_PATHWAYS_LOG2-1:0]         o_grant,
  output logic [15:0]                          pkt_count,
  output logic [15:0]                          trunc_count
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_e;

  localparam logic [PKT_LEN_WIDTH:0] CNT_ONE = 1;

  state_e                         state_q, state_d;
  logic [NUM_PATHWAYS_LOG2-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic [PKT_LEN_WIDTH:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]                    pkt_count_q, pkt_count_d;
  logic [15:0]                    trunc_count_q, trunc_count_d;
  logic [15:0]                    hdr_time_q, hdr_time_d;

  logic [NUM_PATHWAYS-1:0][DATA_WIDTH-1:0] lane_data;
  logic [NUM_PATHWAYS-1:0]        cand;
  logic                           arb_found;
  logic [NUM_PATHWAYS_LOG2-1:0]   arb_idx;
  logic [PKT_LEN_WIDTH:0]         pkt_limit, beat_inc;
  logic                           at_limit, g_vld, g_last, g_acc;
  logic                           unused_time;

  assign lane_data   = i_tdata;
  assign unused_time = ^cur_time[63:16];
  assign tx_en_out   = |(tx_en & pathway_enable);
  assign o_grant     = grant_q;
  assign pkt_count   = pkt_count_q;
  assign trunc_count = trunc_count_q;

  assign g_vld  = i_tvalid[grant_q];
  assign g_last = i_tlast[grant_q];
  assign g_acc  = g_vld & o_tready;

  // A zero length setting means the full 2^PKT_LEN_WIDTH range.
  assign pkt_limit = (max_pkt_len == '0) ? {1'b1, {PKT_LEN_WIDTH{1'b0}}} : {1'b0, max_pkt_len};
  assign beat_inc  = beat_cnt_q + CNT_ONE;
  assign at_limit  = (beat_inc == pkt_limit);

  for (genvar l = 0; l < NUM_PATHWAYS; l++) begin : g_lane
    mrr_poa_lane #(.IDX_W(NUM_PATHWAYS_LOG2), .LANE(l)) u_lane (
      .grant     (grant_q),
      .data_act  (state_q == DATA),
      .flush_act (state_q == FLUSH),
      .o_tready  (o_tready),
      .tready    (i_tready[l])
    );
  end

  // First enabled, valid pathway at or after the rr pointer.
  always_comb begin
    cand      = i_tvalid & pathway_enable;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_PATHWAYS; i++) begin
      if (!arb_found && cand[(int'(rr_q) + i) % NUM_PATHWAYS]) begin
        arb_found = 1'b1;
        arb_idx   = NUM_PATHWAYS_LOG2'((int'(rr_q) + i) % NUM_PATHWAYS);
      end
    end
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;
    case (state_q)
      HDR: begin
        o_tvalid = 1'b1;
        o_tdata  = DATA_WIDTH'({8'hA5, 8'(grant_q), hdr_time_q});
      end
      DATA: begin
        o_tvalid = g_vld;
        o_tdata  = lane_data[grant_q];
        o_tlast  = g_last | at_limit;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_count_d   = pkt_count_q;
    trunc_count_d = trunc_count_q;
    hdr_time_d    = hdr_time_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (arb_found) begin
          grant_d    = arb_idx;
          rr_d       = (int'(arb_idx) == NUM_PATHWAYS - 1) ? '0
                                                           : NUM_PATHWAYS_LOG2'(int'(arb_idx) + 1);
          hdr_time_d = cur_time[15:0];
          state_d    = header_en ? HDR : DATA;
        end
      end
      HDR: begin
        beat_cnt_d = '0;
        if (o_tready) state_d = DATA;
      end
      DATA: begin
        if (g_acc) begin
          beat_cnt_d = beat_inc;
          if (g_last) begin
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = IDLE;
          end else if (at_limit) begin
            pkt_count_d = pkt_count_q + 16'd1;
            if (trunc_count_q != 16'hFFFF) trunc_count_d = trunc_count_q + 16'd1;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (g_vld && g_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      beat_cnt_q    <= '0;
      pkt_count_q   <= '0;
      trunc_count_q <= '0;
      hdr_time_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      beat_cnt_q    <= beat_cnt_d;
      pkt_count_q   <= pkt_count_d;
      trunc_count_q <= trunc_count_d;
      hdr_time_q    <= hdr_time_d;
    end
  end
endmodule

// File: tb/tb_mrr_pathway_output_arbiter.sv
// Randomized bench for mrr_pathway_output_arbiter: per-pathway packet queues feed the DUT and a
// packet-level model predicts grant order, header words, truncation and counters.
`timescale 1ns/1ps
module tb_mrr_pathway_output_arbiter;
  localparam int N = 4, DW = 32, LW = 10;

  logic            clk = 1'b0, rst = 1'b1;
  logic [DW*N-1:0] i_tdata = '0;
  logic [N-1:0]    i_tvalid = '0, i_tlast = '0, i_tready;
  logic [DW-1:0]   o_tdata;
  logic            o_tvalid, o_tlast, o_tready = 1'b0;
  logic [N-1:0]    pathway_enable = '0, tx_en = '0;
  logic            header_en = 1'b0, tx_en_out;
  logic [LW-1:0]   max_pkt_len = '0;
  logic [63:0]     cur_time = '0;
  logic [1:0]      o_grant;
  logic [15:0]     pkt_count, trunc_count;

  mrr_pathway_output_arbiter #(.NUM_PATHWAYS(N), .NUM_PATHWAYS_LOG2(2), .DATA_WIDTH(DW),
                               .PKT_LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .pathway_enable(pathway_enable), .header_en(header_en),
    .max_pkt_len(max_pkt_len), .cur_time(cur_time), .tx_en(tx_en), .tx_en_out(tx_en_out),
    .o_grant(o_grant), .pkt_count(pkt_count), .trunc_count(trunc_count));

  always #5 clk = ~clk;

  // source queues and driver state
  logic [DW-1:0] src_d[N][$];
  bit            src_l[N][$];
  bit            pkt_start[N], vhold[N], acc[N];
  // settings of the current phase
  logic [N-1:0]  cfg_en;
  bit            cfg_hdr;
  int            cfg_len, cfg_mode;
  // packet-level reference model
  int            rr_m, g_m, pkt_m, trunc_m;
  bit            in_pkt, hdr_pend, stall_prev;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   stall_word;
  logic [15:0]   t_prev;
  int            errs = 0, checks = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic load(int p, int n);
    for (int k = 0; k < n; k++) begin
      src_d[p].push_back($urandom);
      src_l[p].push_back(k == n - 1);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      src_d[p].delete(); src_l[p].delete();
      pkt_start[p] = 1; vhold[p] = 0; acc[p] = 0;
    end
    rr_m = 0; g_m = 0; pkt_m = 0; trunc_m = 0;
    in_pkt = 0; hdr_pend = 0; stall_prev = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (acc[p] && src_d[p].size() > 0) begin
        pkt_start[p] = src_l[p][0];
        void'(src_d[p].pop_front());
        void'(src_l[p].pop_front());
        vhold[p] = 0;
      end
      acc[p] = 0;
      // first beat of a packet is offered at once; later beats may start late but then hold
      if (src_d[p].size() == 0) vhold[p] = 0;
      else if (pkt_start[p] || $urandom_range(0, 3) != 0) vhold[p] = 1;
      i_tvalid[p] = vhold[p];
      i_tdata[p*DW +: DW] = vhold[p] ? src_d[p][0] : $urandom;
      i_tlast[p] = vhold[p] ? src_l[p][0] : 1'($urandom);
    end
    pathway_enable = cfg_en;
    header_en      = cfg_hdr;
    max_pkt_len    = LW'(cfg_len);
    case (cfg_mode)
      0: o_tready = 1'b1;
      1: o_tready = ($urandom_range(0, 3) != 0);
      default: o_tready = ~o_tready;
    endcase
    t_prev   = cur_time[15:0];
    cur_time = {$urandom, $urandom};
    tx_en    = 4'($urandom);
  endtask

  task automatic sample();
    logic [N-1:0] allowed;
    logic [DW:0]  e;
    int g, plen, lim, n;
    if (!in_pkt && o_tvalid) begin
      g = -1;
      for (int i = 0; i < N; i++)
        if (g < 0 && cfg_en[(rr_m + i) % N] && src_d[(rr_m + i) % N].size() > 0) g = (rr_m + i) % N;
      if (g < 0) chk("spurious_start", 64'(1), 64'(0));
      else begin
        chk("grant", 64'(o_grant), 64'(g));
        g_m = g; rr_m = (g + 1) % N; in_pkt = 1; hdr_pend = cfg_hdr;
        if (cfg_hdr) exp_q.push_back({1'b0, 8'hA5, 8'(g), t_prev});
        plen = 0;
        for (int k = 0; k < src_l[g].size(); k++) if (plen == 0 && src_l[g][k]) plen = k + 1;
        lim = (cfg_len == 0) ? (1 << LW) : cfg_len;
        n = (plen < lim) ? plen : lim;
        for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, src_d[g][k]});
        pkt_m = (pkt_m + 1) % 65536;
        if (plen > lim && trunc_m < 65535) trunc_m++;
      end
    end
    allowed = (in_pkt && hdr_pend) ? '0 : (N'(1) << g_m);
    chk("tready_mask", 64'(i_tready & ~allowed), 64'(0));
    if (in_pkt && !hdr_pend) chk("tready_pass", 64'(i_tready[g_m]), 64'(o_tready));
    chk("tx_en_out", 64'(tx_en_out), 64'(|(tx_en & cfg_en)));
    if (stall_prev) begin
      chk("stall_vld", 64'(o_tvalid), 64'(1));
      chk("stall_word", 64'({o_tlast, o_tdata}), 64'(stall_word));
    end
    stall_prev = o_tvalid && !o_tready;
    stall_word = {o_tlast, o_tdata};
    if (o_tvalid && o_tready) begin
      if (!in_pkt || exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("beat", 64'({o_tlast, o_tdata}), 64'(e));
        hdr_pend = 0;
        if (exp_q.size() == 0) in_pkt = 0;
      end
    end
    for (int p = 0; p < N; p++) acc[p] = i_tvalid[p] && i_tready[p];
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic drain();
    bit busy;
    int cyc = 0;
    do begin
      step();
      cyc++;
      busy = in_pkt;
      for (int p = 0; p < N; p++) if (cfg_en[p] && src_d[p].size() > 0) busy = 1;
    end while (busy && cyc < 3000);
    if (busy) chk("drain_timeout", 64'(1), 64'(0));
    step(); step();
    chk("pkt_count", 64'(pkt_count), 64'(pkt_m));
    chk("trunc_count", 64'(trunc_count), 64'(trunc_m));
  endtask

  task automatic set_phase(logic [N-1:0] en, bit hdr, int len, int mode);
    cfg_en = en; cfg_hdr = hdr; cfg_len = len; cfg_mode = mode;
  endtask

  initial begin
    int lens[7] = '{0, 2, 3, 4, 5, 8, 16};
    int cyc;
    model_reset();
    set_phase(4'hF, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(o_tvalid), 64'(0));
    chk("rst_tlast", 64'(o_tlast), 64'(0));
    chk("rst_tdata", 64'(o_tdata), 64'(0));
    chk("rst_tready", 64'(i_tready), 64'(0));
    chk("rst_grant", 64'(o_grant), 64'(0));
    chk("rst_counts", 64'({pkt_count, trunc_count}), 64'(0));
    rst = 1'b0;

    for (int p = 0; p < N; p++) load(p, 3);         // simultaneous offers, expect 0,1,2,3
    drain();
    set_phase(4'hF, 1, 0, 0); load(2, 2); drain();    // header beat
    set_phase(4'hF, 0, 4, 1); load(1, 7); drain();    // truncation and flush
    set_phase(4'b1010, 0, 0, 1);                      // masked arbitration
    for (int p = 0; p < N; p++) begin load(p, 2); load(p, 3); end
    drain();
    set_phase(4'hF, 0, 0, 2); load(0, 5); drain();    // alternating backpressure
    for (int ph = 0; ph < 6; ph++) begin
      set_phase(4'($urandom_range(1, 15)), 1'($urandom), lens[$urandom_range(0, 6)],
             $urandom_range(0, 2));
      for (int p = 0; p < N; p++)
        for (int k = $urandom_range(0, 3); k > 0; k--) load(p, $urandom_range(1, 8));
      drain();
    end
    set_phase(4'hF, 1, 3, 1); drain();
    for (int p = 0; p < N; p++) chk("queues_empty", 64'(src_d[p].size()), 64'(0));

    // reset in the middle of a data packet
    set_phase(4'hF, 0, 0, 0); load(3, 6);
    cyc = 0;
    do begin step(); cyc++; end while (!(in_pkt && !hdr_pend && exp_q.size() < 5) && cyc < 50);
    if (cyc >= 50) chk("mid_pkt_timeout", 64'(1), 64'(0));
    rst = 1'b1; #1;
    chk("midrst_tvalid", 64'(o_tvalid), 64'(0));
    chk("midrst_tready", 64'(i_tready), 64'(0));
    chk("midrst_counts", 64'({pkt_count, trunc_count}), 64'(0));
    chk("midrst_grant", 64'(o_grant), 64'(0));
    model_reset();
    step();
    rst = 1'b0;
    for (int p = 0; p < N; p++) load(p, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
